// File: rtl/regfile_wb_arbiter.sv
// Two-writer arbiter for the register file write port: pipeline writeback has priority,
// mul/div wins after MAX_WAIT denied cycles; tracks mul/div-reserved destinations in busy.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic [31:0] busy,
  output logic        starve_hit
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we3_q, we3_d;
  logic [4:0]       a3_q, a3_d;
  logic [31:0]      wd3_q, wd3_d;
  logic [31:0]      busy_q, busy_d;
  logic             starve_hit_q, starve_hit_d;
  logic             force1, grant0, grant1;

  always_comb begin
    force1 = req0_valid && req1_valid && (cnt_q == MAX_CNT);
    grant1 = req1_valid && (!req0_valid || force1);
    grant0 = req0_valid && !grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Winner's write is presented one cycle after the grant; address 0 is a silent no-op.
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (grant1 && (req1_addr != 5'd0)) begin
      we3_d = 1'b1;
      a3_d  = req1_addr;
      wd3_d = req1_data;
    end else if (grant0 && (req0_addr != 5'd0)) begin
      we3_d = 1'b1;
      a3_d  = req0_addr;
      wd3_d = req0_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!req1_valid || grant1) begin
      cnt_d = '0;
    end else if (cnt_q < MAX_CNT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    starve_hit_d = force1;
  end

  // Clear before set so a same-cycle reserve of the retiring register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (grant1 && (req1_addr != 5'd0)) begin
      busy_d[req1_addr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != 5'd0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      we3_q        <= 1'b0;
      a3_q         <= 5'd0;
      wd3_q        <= 32'd0;
      busy_q       <= 32'd0;
      starve_hit_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      we3_q        <= we3_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      busy_q       <= busy_d;
      starve_hit_q <= starve_hit_d;
    end
  end

  assign we3        = we3_q;
  assign a3         = a3_q;
  assign wd3        = wd3_q;
  assign busy       = busy_q;
  assign starve_hit = starve_hit_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: grants checked inline per task, writes checked
// against a queue of expected (addr, data) pairs by a monitor.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] busy;
  logic        starve_hit;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;

  regfile_wb_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .we3(we3), .a3(a3), .wd3(wd3), .busy(busy), .starve_hit(starve_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  function automatic wr_t mk(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every write on the port must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got a3=%0d wd3=%h required=no write", a3, wd3);
      end else begin
        mon_e = exp_q.pop_front();
        if (a3 !== mon_e.a || wd3 !== mon_e.d) begin
          failures++;
          $display("FAIL wr_data got a3=%0d wd3=%h required a3=%0d wd3=%h", a3, wd3, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_1234;
    step(); step();
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rst_ready0 got=%b required=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL rst_ready1 got=%b required=0", req1_ready); end
    checks++; if (we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'd0) begin failures++; $display("FAIL rst_out got we3=%b a3=%0d wd3=%h required 0/0/0", we3, a3, wd3); end
    checks++; if (busy !== 32'd0 || starve_hit !== 1'b0) begin failures++; $display("FAIL rst_state got busy=%h starve=%b required 0/0", busy, starve_hit); end
    step();
    rst = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL rst_nowrite got=%b required=0", we3); end
    step();
  endtask

  task automatic test_req0_only();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL r0_ready got=%b%b required=10", req0_ready, req1_ready); end
    exp_q.push_back(mk(5'd5, 32'hDEAD_BEEF));
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL r0_write got we3=%b a3=%0d wd3=%h required 1/5/deadbeef", we3, a3, wd3); end
    step();
    @(negedge clk);
    checks++; if (we3 !== 1'b0 || a3 !== 5'd5) begin failures++; $display("FAIL r0_single got we3=%b a3=%0d required 0/5", we3, a3); end
    step();
  endtask

  task automatic test_contention();
    int  k;
    logic exp0, exp1, exps;
    k = 0;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = $urandom;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h0000_9999;
    for (int i = 0; i <= 10; i++) begin
      if (i == 10) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(negedge clk);
      exp1 = (i == 4) || (i == 9);
      exp0 = (i < 10) && !exp1;
      exps = (i == 5) || (i == 10);
      checks++; if (req0_ready !== exp0 || req1_ready !== exp1) begin failures++; $display("FAIL cont_grant[%0d] got=%b%b required=%b%b", i, req0_ready, req1_ready, exp0, exp1); end
      checks++; if (starve_hit !== exps) begin failures++; $display("FAIL cont_starve[%0d] got=%b required=%b", i, starve_hit, exps); end
      if (exp0) exp_q.push_back(mk(req0_addr, req0_data));
      if (exp1) exp_q.push_back(mk(req1_addr, req1_data));
      step();
      if (exp0) begin
        k++;
        req0_addr = 5'(1 + (k % 30));
        req0_data = $urandom;
      end
      if (exp1) begin
        req1_addr = 5'd10; req1_data = 32'h0000_AAAA;
      end
    end
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    step();
    rsv_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL sb_set got=%h required=00000080", busy); end
    rsv_valid = 1'b1;
    step();
    rsv_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL sb_reset_again got=%h required=00000080", busy); end
    step();
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hCAFE_0007;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL sb_grant got=%b%b required=01", req0_ready, req1_ready); end
    exp_q.push_back(mk(5'd7, 32'hCAFE_0007));
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 32'd0 || we3 !== 1'b1 || a3 !== 5'd7) begin failures++; $display("FAIL sb_clear got busy=%h we3=%b a3=%0d required 0/1/7", busy, we3, a3); end
    step();
  endtask

  task automatic test_set_clear_same();
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    step();
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h0000_0077;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL sc_grant got=%b required=1", req1_ready); end
    exp_q.push_back(mk(5'd7, 32'h0000_0077));
    step();
    rsv_valid = 1'b0; req1_data = 32'h0000_0078;
    @(negedge clk);
    checks++; if (busy !== 32'h0000_0080 || we3 !== 1'b1 || a3 !== 5'd7) begin failures++; $display("FAIL sc_setwins got busy=%h we3=%b a3=%0d required 00000080/1/7", busy, we3, a3); end
    exp_q.push_back(mk(5'd7, 32'h0000_0078));
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL sc_cleanup got=%h required=0", busy); end
    step();
  endtask

  task automatic test_addr0();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h0000_0001;
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL a0_ready got=%b required=1", req0_ready); end
    step();
    req0_valid = 1'b0; rsv_valid = 1'b0;
    @(negedge clk);
    checks++; if (we3 !== 1'b0 || busy !== 32'd0) begin failures++; $display("FAIL a0_nowrite got we3=%b busy=%h required 0/0", we3, busy); end
    step();
  endtask

  task automatic test_reset_mid();
    logic exp0, exp1;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'h1200_0001;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h0000_00BB;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rm_pre[%0d] got=%b required=1", i, req0_ready); end
      exp_q.push_back(mk(req0_addr, req0_data));
      step();
      rsv_valid = 1'b0; req0_data = req0_data + 32'd1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL rm_rst_ready got=%b%b required=10", req0_ready, req1_ready); end
    step();
    rst = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (we3 !== 1'b0 || busy !== 32'd0 || starve_hit !== 1'b0) begin failures++; $display("FAIL rm_after got we3=%b busy=%h starve=%b required 0/0/0", we3, busy, starve_hit); end
      end
      exp1 = (i == 4);
      exp0 = !exp1;
      checks++; if (req0_ready !== exp0 || req1_ready !== exp1) begin failures++; $display("FAIL rm_grant[%0d] got=%b%b required=%b%b", i, req0_ready, req1_ready, exp0, exp1); end
      if (exp0) exp_q.push_back(mk(req0_addr, req0_data));
      if (exp1) exp_q.push_back(mk(req1_addr, req1_data));
      step();
      req0_data = req0_data + 32'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    rsv_valid = 1'b0; rsv_addr = 5'd0;
    test_reset();
    test_req0_only();
    test_contention();
    test_scoreboard();
    test_set_clear_same();
    test_addr0();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wr_missing got pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
